// File: rtl/microwave_pkg.sv
// Shared types and constants for the microwave oven controller.
package microwave_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    COOK = 1'b1
  } state_t;

  // Display digits: index 0 = seconds ones, 1 = seconds tens, 2 = minutes.
  localparam int NUM_DIGITS = 3;

  // 7-segment patterns, bit order {g,f,e,d,c,b,a}, active-high.
  localparam logic [6:0] SEG_0 = 7'h3F;
  localparam logic [6:0] SEG_1 = 7'h06;
  localparam logic [6:0] SEG_2 = 7'h5B;
  localparam logic [6:0] SEG_3 = 7'h4F;
  localparam logic [6:0] SEG_4 = 7'h66;
  localparam logic [6:0] SEG_5 = 7'h6D;
  localparam logic [6:0] SEG_6 = 7'h7D;
  localparam logic [6:0] SEG_7 = 7'h07;
  localparam logic [6:0] SEG_8 = 7'h7F;
  localparam logic [6:0] SEG_9 = 7'h6F;
  localparam logic [6:0] SEG_BLANK = 7'h00;

endpackage

// File: rtl/bcd_to_7seg.sv
// BCD digit to 7-segment decoder; codes 10..15 blank the digit.
module bcd_to_7seg
  import microwave_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] segs
);

  // Pure lookup from digit value to segment pattern.
  always_comb begin
    segs = SEG_BLANK;
    case (digit)
      4'd0: segs = SEG_0;
      4'd1: segs = SEG_1;
      4'd2: segs = SEG_2;
      4'd3: segs = SEG_3;
      4'd4: segs = SEG_4;
      4'd5: segs = SEG_5;
      4'd6: segs = SEG_6;
      4'd7: segs = SEG_7;
      4'd8: segs = SEG_8;
      4'd9: segs = SEG_9;
      default: segs = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/microwave.sv
// Microwave controller: keypad M:SS entry, start/stop/clear, door interlock,
// 1 s BCD countdown driving the magnetron enable and three 7-segment digits.
module microwave
  import microwave_pkg::*;
#(
  parameter int CLK_HZ = 50
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] keypad,
  input  logic       startn,
  input  logic       stopn,
  input  logic       clearn,
  input  logic       door_closed,
  output logic       mag,
  output logic [6:0] sec_ones_segs,
  output logic [6:0] sec_tens_segs,
  output logic [6:0] min_segs
);

  localparam int DIV_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_HZ - 1);

  state_t                          state_q, state_d;
  logic [DIV_W-1:0]                div_q;
  logic [9:0]                      key_q;
  logic [NUM_DIGITS-1:0][3:0]      dig_q;
  logic [NUM_DIGITS-1:0][3:0]      dig_dec;
  logic [NUM_DIGITS-1:0][6:0]      segs;
  logic [3:0]                      key_digit;
  logic                            press;
  logic                            time_zero;
  logic                            last_sec;
  logic                            start_ok;
  logic                            pause;
  logic                            tick;

  // Key press = all-zero to non-zero transition; highest set bit wins.
  always_comb begin
    key_digit = 4'd0;
    for (int i = 0; i < 10; i++)
      if (keypad[i]) key_digit = 4'(i);
    press = (key_q == 10'd0) && (keypad != 10'd0);
  end

  // Control qualifiers shared by FSM, counter and divider.
  always_comb begin
    time_zero = (dig_q == '0);
    last_sec  = (dig_q[2] == 4'd0) && (dig_q[1] == 4'd0) && (dig_q[0] == 4'd1);
    start_ok  = !startn && stopn && clearn && door_closed && !time_zero;
    pause     = !stopn || !door_closed;
    tick      = (state_q == COOK) && (div_q == DIV_LAST);
  end

  // One-second BCD decrement; tens above 5 are simply counted down as entered.
  always_comb begin
    dig_dec = dig_q;
    if (dig_q[0] != 4'd0) begin
      dig_dec[0] = dig_q[0] - 4'd1;
    end else begin
      dig_dec[0] = 4'd9;
      if (dig_q[1] != 4'd0) begin
        dig_dec[1] = dig_q[1] - 4'd1;
      end else begin
        dig_dec[1] = 4'd5;
        dig_dec[2] = dig_q[2] - 4'd1;
      end
    end
  end

  // Next state: clear dominates; a pause in the tick cycle suppresses that tick.
  always_comb begin
    state_d = state_q;
    if (!clearn) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (start_ok) state_d = COOK;
        COOK:    if (pause || (tick && last_sec)) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // State register and registered magnetron enable.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      mag     <= 1'b0;
    end else begin
      state_q <= state_d;
      mag     <= (state_d == COOK);
    end
  end

  // Divider runs only while cooking continues; any other cycle restarts it.
  always_ff @(posedge clk) begin
    if (rst)                                        div_q <= '0;
    else if (state_q != COOK || state_d != COOK)    div_q <= '0;
    else if (tick)                                  div_q <= '0;
    else                                            div_q <= div_q + DIV_W'(1);
  end

  // Key history for edge detection.
  always_ff @(posedge clk) begin
    if (rst) key_q <= '0;
    else     key_q <= keypad;
  end

  // Digit registers: clear, shift-in entry while idle, countdown while cooking.
  always_ff @(posedge clk) begin
    if (rst || !clearn)
      dig_q <= '0;
    else if (state_q == IDLE && press)
      dig_q <= {dig_q[1], dig_q[0], key_digit};
    else if (state_q == COOK && !pause && tick)
      dig_q <= dig_dec;
  end

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dec
    bcd_to_7seg u_dec (
      .digit (dig_q[g]),
      .segs  (segs[g])
    );
  end

  assign sec_ones_segs = segs[0];
  assign sec_tens_segs = segs[1];
  assign min_segs      = segs[2];

endmodule

// File: tb/tb_microwave.sv
// Bench for microwave: directed scenarios then random front-panel activity,
// compared every cycle against a digit-level reference model.
module tb_microwave;

  localparam int CLK_HZ = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] keypad;
  logic       startn, stopn, clearn, door_closed;
  logic       mag;
  logic [6:0] sec_ones_segs, sec_tens_segs, min_segs;

  int errors = 0;
  int checks = 0;

  // reference model state
  int  m_min, m_tens, m_ones, m_div;
  bit  m_cook;
  logic [9:0] m_prev;

  microwave #(.CLK_HZ(CLK_HZ)) dut (
    .clk           (clk),
    .rst           (rst),
    .keypad        (keypad),
    .startn        (startn),
    .stopn         (stopn),
    .clearn        (clearn),
    .door_closed   (door_closed),
    .mag           (mag),
    .sec_ones_segs (sec_ones_segs),
    .sec_tens_segs (sec_tens_segs),
    .min_segs      (min_segs)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'h3F; 1: return 7'h06; 2: return 7'h5B; 3: return 7'h4F;
      4: return 7'h66; 5: return 7'h6D; 6: return 7'h7D; 7: return 7'h07;
      8: return 7'h7F; 9: return 7'h6F;
      default: return 7'h00;
    endcase
  endfunction

  // Apply the oven rules to the model for one clock edge with current inputs.
  task automatic model_edge();
    bit press, zero;
    int dig;
    press = (m_prev == 10'd0) && (keypad != 10'd0);
    dig = 0;
    for (int i = 0; i < 10; i++) if (keypad[i]) dig = i;
    zero = (m_min == 0 && m_tens == 0 && m_ones == 0);
    if (rst) begin
      m_min = 0; m_tens = 0; m_ones = 0; m_cook = 0; m_div = 0;
    end else if (!clearn) begin
      m_min = 0; m_tens = 0; m_ones = 0; m_cook = 0; m_div = 0;
    end else if (!m_cook) begin
      if (!startn && stopn && door_closed && !zero) begin
        m_cook = 1; m_div = 0;
      end
      if (press) begin
        m_min = m_tens; m_tens = m_ones; m_ones = dig;
      end
    end else if (!stopn || !door_closed) begin
      m_cook = 0; m_div = 0;
    end else if (m_div == CLK_HZ - 1) begin
      m_div = 0;
      if (m_ones > 0) m_ones--;
      else begin
        m_ones = 9;
        if (m_tens > 0) m_tens--;
        else begin m_tens = 5; m_min--; end
      end
      if (m_min == 0 && m_tens == 0 && m_ones == 0) m_cook = 0;
    end else begin
      m_div++;
    end
    m_prev = rst ? 10'd0 : keypad;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("mag", {31'd0, mag}, {31'd0, m_cook});
    chk("disp", {11'd0, min_segs, sec_tens_segs, sec_ones_segs},
        {11'd0, seg_of(m_min), seg_of(m_tens), seg_of(m_ones)});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic press_key(input int d);
    logic [9:0] k;
    k = 10'd1 << d;
    keypad = k; step();
    keypad = '0; step();
  endtask

  task automatic pulse_start();
    startn = 1'b0; step(); startn = 1'b1;
  endtask

  task automatic chk_disp(input string tag, input logic [20:0] exp);
    chk(tag, {11'd0, min_segs, sec_tens_segs, sec_ones_segs}, {11'd0, exp});
  endtask

  initial begin
    rst = 1'b1; keypad = '0; startn = 1'b1; stopn = 1'b1; clearn = 1'b1; door_closed = 1'b1;
    m_prev = '0; m_min = 0; m_tens = 0; m_ones = 0; m_cook = 0; m_div = 0;
    idle(2);
    rst = 1'b0;
    chk_disp("reset_disp", {7'h3F, 7'h3F, 7'h3F});
    chk("reset_mag", {31'd0, mag}, 32'd0);

    // 1: entry 1,9,9
    press_key(1); press_key(9); press_key(9);
    chk_disp("entry_199", {7'h06, 7'h6F, 7'h6F});
    chk("entry_mag", {31'd0, mag}, 32'd0);

    // 2: full cook of 1:99
    pulse_start();
    chk("start_mag", {31'd0, mag}, 32'd1);
    idle(4);
    chk_disp("first_tick", {7'h06, 7'h6F, 7'h7F});
    idle(4 * 158);
    chk_disp("done_disp", {7'h3F, 7'h3F, 7'h3F});
    chk("done_mag", {31'd0, mag}, 32'd0);

    // 3: door interlock pause and resume
    press_key(5);
    pulse_start();
    idle(8);
    door_closed = 1'b0; step();
    chk_disp("door_hold", {7'h3F, 7'h3F, 7'h4F});
    chk("door_mag", {31'd0, mag}, 32'd0);
    pulse_start();
    chk("door_open_start", {31'd0, mag}, 32'd0);
    door_closed = 1'b1; idle(2);
    pulse_start();
    idle(12);
    chk_disp("resume_done", {7'h3F, 7'h3F, 7'h3F});

    // 4: stop pause, then entry shifts onto held time
    press_key(1); press_key(0);
    pulse_start();
    idle(2);
    stopn = 1'b0; step(); stopn = 1'b1;
    chk_disp("stop_hold", {7'h3F, 7'h06, 7'h3F});
    chk("stop_mag", {31'd0, mag}, 32'd0);
    press_key(4);
    chk_disp("shift_after_pause", {7'h06, 7'h3F, 7'h66});

    // 5: clear while cooking, start at 0:00 ignored
    clearn = 1'b0; step(); clearn = 1'b1;
    press_key(3); press_key(0);
    pulse_start();
    idle(2);
    clearn = 1'b0; step(); clearn = 1'b1;
    chk_disp("clear_disp", {7'h3F, 7'h3F, 7'h3F});
    chk("clear_mag", {31'd0, mag}, 32'd0);
    startn = 1'b0; idle(3); startn = 1'b1;
    chk("zero_start_mag", {31'd0, mag}, 32'd0);

    // 6: multi-bit key picks the highest digit, held key shifts once
    keypad = 10'b1000100000;
    idle(10);
    keypad = '0; step();
    chk_disp("held_multi_key", {7'h3F, 7'h3F, 7'h6F});

    // random front-panel activity
    for (int c = 0; c < 4000; c++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 10)      keypad = 10'($urandom_range(1, 1023));
      else if (r < 45) keypad = keypad;
      else             keypad = '0;
      startn      = ($urandom_range(0, 19) != 0);
      stopn       = ($urandom_range(0, 49) != 0);
      clearn      = ($urandom_range(0, 149) != 0);
      door_closed = ($urandom_range(0, 39) != 0);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
